// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the AHB-Lite interrupt controller.
// Register word offsets are decoded from HADDR[4:2].
package irq_ctrl_pkg;

    localparam int unsigned IRQ_NSRC_MAX = 31;

    localparam logic [2:0] IRQ_PENDING_OFF = 3'd0;
    localparam logic [2:0] IRQ_ENABLE_OFF  = 3'd1;
    localparam logic [2:0] IRQ_TRIG_OFF    = 3'd2;
    localparam logic [2:0] IRQ_CLAIM_OFF   = 3'd3;
    localparam logic [2:0] IRQ_CTRL_OFF    = 3'd4;

    // ID+1 of the lowest set bit, 0 when the vector is empty.
    function automatic logic [5:0] irq_claim_id(input logic [31:0] v);
        logic [5:0] id;
        id = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (v[i-1]) id = 6'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: optional 2-flop synchronizer, edge detector
// and pending latch. Define IRQ_SYNC_EN to insert the synchronizer.
module irq_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    input  logic clear,
    input  logic src,
    output logic pending
);

    logic s;
    logic prev_q;
    logic pend_q;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], src};
    end

    assign s = sync_q[1];
`else
    assign s = src;
`endif

    // Level mode tracks the input and drops any latched edge; in edge mode a
    // new edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= s;
            if (trig) pend_q <= (pend_q & ~clear) | (s & ~prev_q);
            else      pend_q <= s;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/ahbl_irq_ctrl.sv
// AHB-Lite interrupt controller: per-source gateways, enable/trigger/control
// registers, a claim priority encoder and a registered IRQ output.
// Define IRQ_SYNC_EN to synchronize IRQ_SRC inside each gateway.
module ahbl_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 8
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic [2:0]      HSIZE,
    input  logic            HWRITE,
    input  logic            HREADY,
    input  logic            HSEL,
    input  logic [31:0]     HWDATA,
    output logic            HREADYOUT,
    output logic [31:0]     HRDATA,
    input  logic [NSRC-1:0] IRQ_SRC,
    output logic            IRQ
);

    logic            dp_valid;
    logic            dp_write;
    logic [2:0]      dp_addr;

    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] trig_q;
    logic            gie_q;
    logic            irq_q;

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pend_en;
    logic [NSRC-1:0] claim_onehot;
    logic [NSRC-1:0] clear_vec;
    logic [5:0]      claim_id;
    logic            wr_en;
    logic            rd_en;

    logic unused_ok;
    assign unused_ok = &{1'b0, HADDR[31:5], HADDR[1:0], HSIZE, HTRANS[0], HWDATA[31:NSRC]};

    assign HREADYOUT = 1'b1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (HREADY) begin
            dp_valid <= HSEL & HTRANS[1];
            dp_write <= HWRITE;
            dp_addr  <= HADDR[4:2];
        end
    end

    assign wr_en = dp_valid & dp_write;
    assign rd_en = dp_valid & ~dp_write;

    assign pend_en      = pending & enable_q;
    assign claim_id     = irq_claim_id(32'(pend_en));
    // Lowest set bit of pend_en is the source the claim read returns.
    assign claim_onehot = pend_en & ~(pend_en - 1'b1);

    always_comb begin
        clear_vec = '0;
        if (wr_en && dp_addr == IRQ_PENDING_OFF) clear_vec = HWDATA[NSRC-1:0];
        if (rd_en && dp_addr == IRQ_CLAIM_OFF)   clear_vec = clear_vec | claim_onehot;
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk     (HCLK),
            .rst_n   (HRESETn),
            .trig    (trig_q[g]),
            .clear   (clear_vec[g]),
            .src     (IRQ_SRC[g]),
            .pending (pending[g])
        );
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            enable_q <= '0;
            trig_q   <= '0;
            gie_q    <= 1'b0;
        end else if (wr_en) begin
            case (dp_addr)
                IRQ_ENABLE_OFF: enable_q <= HWDATA[NSRC-1:0];
                IRQ_TRIG_OFF:   trig_q   <= HWDATA[NSRC-1:0];
                IRQ_CTRL_OFF:   gie_q    <= HWDATA[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) irq_q <= 1'b0;
        else          irq_q <= gie_q & (|pend_en);
    end

    assign IRQ = irq_q;

    always_comb begin
        HRDATA = '0;
        if (rd_en) begin
            case (dp_addr)
                IRQ_PENDING_OFF: HRDATA = 32'(pending);
                IRQ_ENABLE_OFF:  HRDATA = 32'(enable_q);
                IRQ_TRIG_OFF:    HRDATA = 32'(trig_q);
                IRQ_CLAIM_OFF:   HRDATA = 32'(claim_id);
                IRQ_CTRL_OFF:    HRDATA = {31'd0, gie_q};
                default:         HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_irq_ctrl.sv
// Directed self-checking bench for ahbl_irq_ctrl (default build, NSRC=8).
module tb_ahbl_irq_ctrl;

    localparam int unsigned NSRC = 8;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic [2:0]      HSIZE;
    logic            HWRITE;
    logic            HREADY;
    logic            HSEL;
    logic [31:0]     HWDATA;
    logic            HREADYOUT;
    logic [31:0]     HRDATA;
    logic [NSRC-1:0] IRQ_SRC;
    logic            IRQ;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] rd;

    ahbl_irq_ctrl #(.NSRC(NSRC)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HSEL      (HSEL),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .IRQ_SRC   (IRQ_SRC),
        .IRQ       (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = addr;
        tick();
        bus_idle();
        HWDATA = data;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = addr;
        tick();
        bus_idle();
        data = HRDATA;
        tick();
    endtask

    initial begin
        HRESETn = 1'b0;
        HSIZE   = 3'b010;
        HREADY  = 1'b1;
        HWDATA  = '0;
        IRQ_SRC = '0;
        bus_idle();
        repeat (3) tick();
        HRESETn = 1'b1;
        tick();

        // Reset state of every offset
        for (int i = 0; i < 8; i++) begin
            ahb_read(32'(i * 4), rd);
            check($sformatf("reset_rd_%0h", i * 4), rd, 32'h0);
        end
        check("reset_irq", {31'd0, IRQ}, 32'h0);
        check("hreadyout", {31'd0, HREADYOUT}, 32'h1);

        // Bits above NSRC, reserved and CLAIM writes
        ahb_write(32'h04, 32'hFFFF_FFFF);
        ahb_read(32'h04, rd);
        check("enable_mask", rd, 32'h0000_00FF);
        ahb_write(32'h14, 32'hFFFF_FFFF);
        ahb_read(32'h14, rd);
        check("reserved_rd", rd, 32'h0);
        ahb_write(32'h0C, 32'h5);
        ahb_read(32'h0C, rd);
        check("claim_wr_ignored", rd, 32'h0);

        // Edge source 2
        ahb_write(32'h04, 32'h04);
        ahb_write(32'h08, 32'h04);
        ahb_write(32'h10, 32'h01);
        ahb_read(32'h10, rd);
        check("ctrl_rd", rd, 32'h1);
        IRQ_SRC = 8'h04;
        tick();
        IRQ_SRC = 8'h00;
        check("edge_irq_e0", {31'd0, IRQ}, 32'h0);
        tick();
        check("edge_irq_e1", {31'd0, IRQ}, 32'h1);
        ahb_read(32'h00, rd);
        check("edge_pending", rd, 32'h04);
        ahb_read(32'h0C, rd);
        check("claim_src2", rd, 32'h3);
        ahb_read(32'h0C, rd);
        check("claim_src2_again", rd, 32'h0);
        check("edge_irq_fall", {31'd0, IRQ}, 32'h0);

        // Level source 5
        ahb_write(32'h04, 32'h20);
        ahb_write(32'h08, 32'h00);
        IRQ_SRC = 8'h20;
        tick();
        tick();
        check("level_irq", {31'd0, IRQ}, 32'h1);
        ahb_read(32'h0C, rd);
        check("claim_lvl_1", rd, 32'h6);
        ahb_read(32'h0C, rd);
        check("claim_lvl_2", rd, 32'h6);
        ahb_write(32'h00, 32'h20);
        ahb_read(32'h00, rd);
        check("level_w1c_noeffect", rd, 32'h20);
        IRQ_SRC = 8'h00;
        tick();
        ahb_read(32'h00, rd);
        check("level_drop_pending", rd, 32'h0);
        check("level_drop_irq", {31'd0, IRQ}, 32'h0);

        // Two edge sources, priority order
        ahb_write(32'h08, 32'h42);
        ahb_write(32'h04, 32'h42);
        IRQ_SRC = 8'h42;
        tick();
        IRQ_SRC = 8'h00;
        tick();
        ahb_read(32'h0C, rd);
        check("claim_prio_1", rd, 32'h2);
        ahb_read(32'h0C, rd);
        check("claim_prio_2", rd, 32'h7);
        ahb_read(32'h0C, rd);
        check("claim_prio_3", rd, 32'h0);
        tick();
        check("prio_irq_fall", {31'd0, IRQ}, 32'h0);

        // Edge on source 0 coincides with a W1C of bit 0: set wins
        ahb_write(32'h08, 32'h01);
        ahb_write(32'h04, 32'h01);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h00;
        tick();
        bus_idle();
        HWDATA  = 32'h01;
        IRQ_SRC = 8'h01;
        tick();
        IRQ_SRC = 8'h00;
        ahb_read(32'h00, rd);
        check("set_wins_w1c", rd, 32'h01);
        ahb_write(32'h00, 32'h01);
        ahb_read(32'h00, rd);
        check("w1c_clears", rd, 32'h0);

        // Global enable off keeps pending but masks IRQ
        IRQ_SRC = 8'h01;
        tick();
        IRQ_SRC = 8'h00;
        tick();
        check("gie_irq_on", {31'd0, IRQ}, 32'h1);
        ahb_write(32'h10, 32'h00);
        tick();
        check("gie_off_irq", {31'd0, IRQ}, 32'h0);
        ahb_read(32'h00, rd);
        check("gie_off_pending", rd, 32'h01);

        // Edge to level discards the latch
        ahb_write(32'h08, 32'h00);
        ahb_read(32'h00, rd);
        check("trig_to_level", rd, 32'h0);

        // Asynchronous reset during a write data phase
        ahb_write(32'h10, 32'h01);
        ahb_write(32'h08, 32'h01);
        IRQ_SRC = 8'h01;
        tick();
        IRQ_SRC = 8'h00;
        tick();
        check("pre_reset_irq", {31'd0, IRQ}, 32'h1);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h04;
        tick();
        bus_idle();
        HWDATA = 32'hFF;
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_rst_irq", {31'd0, IRQ}, 32'h0);
        tick();
        HRESETn = 1'b1;
        tick();
        ahb_read(32'h04, rd);
        check("rst_enable", rd, 32'h0);
        ahb_read(32'h08, rd);
        check("rst_trig", rd, 32'h0);
        ahb_read(32'h10, rd);
        check("rst_ctrl", rd, 32'h0);
        ahb_read(32'h00, rd);
        check("rst_pending", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
